vga_vtim_gen: RTL and testbench

- Parametrised video timing generator: one instance produces horizontal timing, a second (ena = Done of the first) produces vertical timing.
- Generates sync, gate (active video), a done-per-period strobe, and an in-gate position count.
- Adds programmable sync polarity, shadowed timing registers (taken only at period start) and a sticky configuration-overflow flag.
- Sits between the CSR block (timing registers) and the pixel/line fetch and output stages.

---
 rtl/vga_vtim_gen_pkg.sv | 19 +
 rtl/vga_vtim_gen_shadow.sv | 75 +++++++
 rtl/vga_vtim_gen.sv | 112 +++++++++++
 tb/tb_vga_vtim_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_vtim_gen_pkg.sv
// +--------------------------------------------------------------------+
// | vga_vtim_gen_pkg: shared widths and state encoding for vga_vtim_gen |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package vga_vtim_gen_pkg;

  localparam int unsigned SW_DEF = 8;
  localparam int unsigned GW_DEF = 16;

  typedef enum logic [0:0] {
    ST_PRE = 1'b0,
    ST_RUN = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vga_vtim_gen_shadow.sv
// +--------------------------------------------------------------------+
// | vga_vtim_gen_shadow: period-start shadow bank, G0/G1 and Ovf       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_vtim_gen_shadow
  import vga_vtim_gen_pkg::*;
#(
  parameter int unsigned SW = SW_DEF,
  parameter int unsigned GW = GW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          pol_i,
  input  logic [SW-1:0] tsync_i,
  input  logic [SW-1:0] tgdel_i,
  input  logic [GW-1:0] tgate_i,
  input  logic [GW-1:0] tlen_i,
  output logic          pol_o,
  output logic [SW-1:0] tsync_o,
  output logic [GW-1:0] tlen_o,
  output logic [GW:0]   g0_o,
  output logic [GW:0]   g1_o,
  output logic          ovf_o
);

  localparam int unsigned EW = GW + 1;

  logic [GW:0]   g0_d;
  logic [GW:0]   g1_d;
  logic          pol_q;
  logic [SW-1:0] tsync_q;
  logic [GW-1:0] tlen_q;
  logic [GW:0]   g0_q;
  logic [GW:0]   g1_q;
  logic          ovf_q;

  // One extra bit so the gate bounds never wrap.
  always_comb begin
    g0_d = EW'(tsync_i) + EW'(tgdel_i) + EW'(2);
    g1_d = g0_d + EW'(tgate_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pol_q   <= 1'b0;
      tsync_q <= '0;
      tlen_q  <= '0;
      g0_q    <= '0;
      g1_q    <= '0;
      ovf_q   <= 1'b0;
    end else if (load_i) begin
      pol_q   <= pol_i;
      tsync_q <= tsync_i;
      tlen_q  <= tlen_i;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      if (g1_d > {1'b0, tlen_i}) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign pol_o   = pol_q;
  assign tsync_o = tsync_q;
  assign tlen_o  = tlen_q;
  assign g0_o    = g0_q;
  assign g1_o    = g1_q;
  assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/vga_vtim_gen.sv
// +--------------------------------------------------------------------+
// | vga_vtim_gen: one axis of video timing (sync, gate, done, pos)     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_vtim_gen
  import vga_vtim_gen_pkg::*;
#(
  parameter int unsigned SW = SW_DEF,
  parameter int unsigned GW = GW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          pol,
  input  logic [SW-1:0] Tsync,
  input  logic [SW-1:0] Tgdel,
  input  logic [GW-1:0] Tgate,
  input  logic [GW-1:0] Tlen,
  output logic          Sync,
  output logic          Gate,
  output logic          Last,
  output logic          Done,
  output logic [GW-1:0] Pos,
  output logic          Ovf
);

  state_e        state_q;
  logic [GW-1:0] k_q, k_d;
  logic [GW:0]   k_ext;
  logic          period_start;

  logic          pol_sh;
  logic [SW-1:0] tsync_sh;
  logic [GW-1:0] tlen_sh;
  logic [GW:0]   g0_sh, g1_sh;

  logic          sync_q, sync_d;
  logic          gate_q, gate_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [GW-1:0] pos_q, pos_d;

  vga_vtim_gen_shadow #(
    .SW(SW),
    .GW(GW)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .load_i (period_start),
    .pol_i  (pol),
    .tsync_i(Tsync),
    .tgdel_i(Tgdel),
    .tgate_i(Tgate),
    .tlen_i (Tlen),
    .pol_o  (pol_sh),
    .tsync_o(tsync_sh),
    .tlen_o (tlen_sh),
    .g0_o   (g0_sh),
    .g1_o   (g1_sh),
    .ovf_o  (Ovf)
  );

  // At k=0 only pol and Tlen==0 matter (G0 >= 2), so the live inputs suffice.
  always_comb begin
    period_start = ena && ((state_q == ST_PRE) || (k_q == tlen_sh));
    k_d          = period_start ? '0 : k_q + GW'(1);
    k_ext        = {1'b0, k_d};
    sync_d       = pol;
    gate_d       = 1'b0;
    last_d       = 1'b0;
    done_d       = (Tlen == '0);
    pos_d        = '0;
    if (!period_start) begin
      sync_d = (k_d <= GW'(tsync_sh)) ? pol_sh : ~pol_sh;
      gate_d = (k_ext >= g0_sh) && (k_ext <= g1_sh);
      last_d = gate_d && ((k_ext == g1_sh) || (k_d == tlen_sh));
      done_d = (k_d == tlen_sh);
      pos_d  = gate_d ? (k_d - g0_sh[GW-1:0]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PRE;
      k_q     <= '0;
      sync_q  <= 1'b0;
      gate_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      pos_q   <= '0;
    end else if (ena) begin
      state_q <= ST_RUN;
      k_q     <= k_d;
      sync_q  <= sync_d;
      gate_q  <= gate_d;
      last_q  <= last_d;
      done_q  <= done_d;
      pos_q   <= pos_d;
    end
  end

  assign Sync = (state_q == ST_PRE) ? ~pol : sync_q;
  assign Gate = gate_q;
  assign Last = last_q;
  assign Done = done_q;
  assign Pos  = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_vtim_gen.sv
// Testbench for vga_vtim_gen: directed scenarios plus randomized traffic
// against a period-level model that tracks k and the latched configuration.
`default_nettype none

module tb_vga_vtim_gen;

  localparam int SW = 8;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst, ena, pol;
  logic [SW-1:0] Tsync, Tgdel;
  logic [GW-1:0] Tgate, Tlen;
  logic          Sync, Gate, Last, Done, Ovf;
  logic [GW-1:0] Pos;
  logic [GW+4:0] obs;

  int total = 0;
  int bad   = 0;

  // model state: position in period and configuration latched at k=0
  bit m_run = 1'b0;
  int m_k = 0, m_tsync = 0, m_tlen = 0, m_g0 = 0, m_g1 = 0;
  bit m_pol = 1'b0, m_ovf = 1'b0;

  vga_vtim_gen #(.SW(SW), .GW(GW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pol(pol),
    .Tsync(Tsync), .Tgdel(Tgdel), .Tgate(Tgate), .Tlen(Tlen),
    .Sync(Sync), .Gate(Gate), .Last(Last), .Done(Done), .Pos(Pos), .Ovf(Ovf)
  );

  assign obs = {Sync, Gate, Last, Done, Ovf, Pos};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0;
      m_k   = 0;
      m_ovf = 1'b0;
    end else if (ena) begin
      if (!m_run || m_k == m_tlen) begin
        m_run   = 1'b1;
        m_k     = 0;
        m_tsync = int'(Tsync);
        m_tlen  = int'(Tlen);
        m_pol   = pol;
        m_g0    = int'(Tsync) + int'(Tgdel) + 2;
        m_g1    = m_g0 + int'(Tgate);
        if (m_g1 > m_tlen) m_ovf = 1'b1;
      end else begin
        m_k = m_k + 1;
      end
    end
  end

  function automatic logic [GW+4:0] exp_vec();
    logic s, g, l, d;
    int p;
    s = m_run ? ((m_k <= m_tsync) ? m_pol : ~m_pol) : ~pol;
    g = m_run && (m_k >= m_g0) && (m_k <= m_g1) && (m_k <= m_tlen);
    l = g && ((m_k == m_g1) || (m_k == m_tlen));
    d = m_run && (m_k == m_tlen);
    p = g ? (m_k - m_g0) : 0;
    return {s, g, l, d, m_ovf, p[GW-1:0]};
  endfunction

  task automatic set_cfg(input int ts, input int tg, input int tga, input int tl, input bit p);
    Tsync = SW'(ts);
    Tgdel = SW'(tg);
    Tgate = GW'(tga);
    Tlen  = GW'(tl);
    pol   = p;
  endtask

  task automatic test_reset();
    logic [GW+4:0] want;
    rst = 1'b1;
    ena = 1'b1;
    set_cfg(2, 1, 3, 11, 1'b1);
    repeat (2) @(negedge clk);
    want = '0;
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs, want);
    end
    pol = 1'b0;
    #1;
    total++;
    if (Sync !== 1'b1) begin
      bad++;
      $display("FAIL reset_sync_live_pol: got %b want 1", Sync);
    end
    pol = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    int gate_cnt = 0, done_cnt = 0, last_cnt = 0, pos_sum = 0;
    set_cfg(2, 1, 3, 11, 1'b1);
    ena = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL basic_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      if (i == 1) begin
        total++;
        if ({Sync, Done} !== 2'b10) begin
          bad++;
          $display("FAIL basic_first_edge: got %b want 10", {Sync, Done});
        end
      end
      gate_cnt += int'(Gate);
      done_cnt += int'(Done);
      last_cnt += int'(Last);
      if (Gate === 1'b1) pos_sum += int'(Pos);
    end
    total++;
    if (gate_cnt != 12 || done_cnt != 3 || last_cnt != 3 || pos_sum != 18) begin
      bad++;
      $display("FAIL basic_counts: got gate=%0d done=%0d last=%0d pos=%0d want 12 3 3 18",
               gate_cnt, done_cnt, last_cnt, pos_sum);
    end
  endtask

  task automatic test_stall();
    int done_cnt = 0;
    ena = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      ena = ~ena;
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL stall_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      done_cnt += int'(Done);
    end
    // 24 enabled edges from k=11: two periods, each Done held for two cycles
    total++;
    if (done_cnt != 4) begin
      bad++;
      $display("FAIL stall_done_count: got %0d want 4", done_cnt);
    end
    ena = 1'b1;
  endtask

  task automatic test_midchange();
    bit found = 1'b0;
    int first_done = -1, second_done = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_k == 4) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midchange_wait: got timeout want k=4");
    end
    set_cfg(2, 1, 3, 7, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL midchange_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      if (Done === 1'b1) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
      if (i == 8) begin
        total++;
        if (Sync !== 1'b0) begin
          bad++;
          $display("FAIL midchange_sync_low: got %b want 0", Sync);
        end
      end
    end
    total++;
    if (first_done != 7 || second_done != 15) begin
      bad++;
      $display("FAIL midchange_done_at: got %0d,%0d want 7,15", first_done, second_done);
    end
  endtask

  task automatic test_trunc();
    int gate_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    set_cfg(2, 1, 9, 11, 1'b1);
    rst = 1'b0;
    ena = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL trunc_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      gate_cnt += int'(Gate);
      if (i == 12) begin
        total++;
        if ({Gate, Last, Done, Ovf} !== 4'b1111) begin
          bad++;
          $display("FAIL trunc_end: got %b want 1111", {Gate, Last, Done, Ovf});
        end
      end
    end
    total++;
    if (gate_cnt != 7) begin
      bad++;
      $display("FAIL trunc_gate_len: got %0d want 7", gate_cnt);
    end
    set_cfg(2, 1, 3, 11, 1'b1);
    repeat (24) @(negedge clk);
    total++;
    if (Ovf !== 1'b1) begin
      bad++;
      $display("FAIL trunc_ovf_sticky: got %b want 1", Ovf);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (Ovf !== 1'b0) begin
      bad++;
      $display("FAIL trunc_ovf_clear: got %b want 0", Ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_degenerate();
    rst = 1'b1;
    @(negedge clk);
    set_cfg(0, 3, 5, 0, 1'b1);
    rst = 1'b0;
    ena = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL degen_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      total++;
      if ({Sync, Done, Gate, Ovf} !== 4'b1101) begin
        bad++;
        $display("FAIL degen_flags%0d: got %b want 1101", i, {Sync, Done, Gate, Ovf});
      end
      ena = ($urandom_range(0, 1) == 1);
    end
    ena = 1'b1;
  endtask

  task automatic test_rst_mid();
    bit found = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    set_cfg(2, 1, 3, 11, 1'b1);
    rst = 1'b0;
    ena = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_k == 6) found = 1'b1;
    end
    total++;
    if (!found || Gate !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_reach_gate: got found=%0b gate=%b want 1 1", found, Gate);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({Sync, Gate, Done, Last, Pos} !== {4'b0000, 16'h0}) begin
      bad++;
      $display("FAIL rstmid_abort: got %h want 0", {Sync, Gate, Done, Last, Pos});
    end
    set_cfg(3, 2, 4, 15, 1'b1);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL rstmid_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      if (i == 16) begin
        total++;
        if (Done !== 1'b1) begin
          bad++;
          $display("FAIL rstmid_new_tlen: got %b want 1", Done);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      ena = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) begin
        set_cfg(($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom_range(0, 12), $urandom_range(0, 24),
                1'($urandom_range(0, 1)));
      end
    end
    rst = 1'b0;
    ena = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    set_cfg(0, 0, 0, 0, 1'b1);
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_midchange();
    test_trunc();
    test_degenerate();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
